// File: rtl/cmp_pkg.sv
// Shared constants and state encoding for the compare-ALU bitmap feeder.
//   ROWS/COLS : bitmap height/width (column word / row word widths)
//   ADDR_W    : image memory address width
//   *_W       : pointer, load-counter and timeout counter widths
package cmp_pkg;

    localparam int unsigned ROWS   = 64;
    localparam int unsigned COLS   = 24;
    localparam int unsigned ADDR_W = 16;

    localparam int unsigned COL_W  = 5;
    localparam int unsigned ROW_W  = 6;
    localparam int unsigned LCNT_W = 7;
    localparam int unsigned TMO_W  = 8;

    typedef enum logic [1:0] {
        FEED_IDLE   = 2'd0,
        FEED_LOAD   = 2'd1,
        FEED_STREAM = 2'd2,
        FEED_DONE   = 2'd3
    } feed_state_e;

endpackage

// File: rtl/cmp_bitbuf.sv
// ROWS x COLS bitmap register array, contents not reset.
//   clk                      : clock
//   we/waddr/wdata           : single row write port
//   raddr_top -> rdata_top   : top-side row read port (combinational)
//   raddr_bot -> rdata_bot   : bottom-side row read port (combinational)
//   cidx -> cdata            : column read port, cdata[j] = row j, bit cidx
module cmp_bitbuf
    import cmp_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [ROW_W-1:0] waddr,
    input  logic [COLS-1:0]  wdata,
    input  logic [ROW_W-1:0] raddr_top,
    output logic [COLS-1:0]  rdata_top,
    input  logic [ROW_W-1:0] raddr_bot,
    output logic [COLS-1:0]  rdata_bot,
    input  logic [COL_W-1:0] cidx,
    output logic [ROWS-1:0]  cdata
);

    logic [COLS-1:0] mem [ROWS];

    // Row write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_top = mem[raddr_top];
    assign rdata_bot = mem[raddr_bot];

    // Transposing mux: gather bit cidx of every row
    always_comb begin
        cdata = '0;
        for (int unsigned j = 0; j < ROWS; j++) begin
            cdata[ROW_W'(j)] = mem[ROW_W'(j)][cidx];
        end
    end

endmodule

// File: rtl/cmp_bitfeed.sv
// Bitmap feeder for the compare ALU: loads a COLS x ROWS bitmap from image
// memory, then streams columns (left to right) and row pairs (top down and
// bottom up) on ALU request.
//   clk, rst (sync, active-high)
//   start, base_addr                 : begin a load at base_addr (IDLE/DONE only)
//   mem_rd, mem_addr, mem_rdata      : image memory read, data 1 cycle after strobe
//   alustart                         : pulse on first STREAM cycle
//   nextcolumn, nextrow, cmp_done    : ALU requests / completion
//   bitcolumn, nextcolumnready       : column word + new-data pulse
//   bitrowtop, nextrowtopready       : top-side row + new-data pulse
//   bitrowbot, nextrowbotready       : bottom-side row + new-data pulse
//   busy, feed_done                  : LOAD/STREAM activity, DONE flag
module cmp_bitfeed
    import cmp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [COLS-1:0]   mem_rdata,
    output logic              alustart,
    input  logic              nextcolumn,
    input  logic              nextrow,
    input  logic              cmp_done,
    output logic [ROWS-1:0]   bitcolumn,
    output logic              nextcolumnready,
    output logic [COLS-1:0]   bitrowtop,
    output logic              nextrowtopready,
    output logic [COLS-1:0]   bitrowbot,
    output logic              nextrowbotready,
    output logic              busy,
    output logic              feed_done
);

    feed_state_e state_q, state_d;

    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              wr_en_q;
    logic [ROW_W-1:0]  wr_idx_q;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  top_q, top_d;
    logic [ROW_W-1:0]  bot_q, bot_d;
    logic              col_exh_q, col_exh_d;
    logic              row_exh_q, row_exh_d;
    logic              primed_q, primed_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic              mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              alustart_d;
    logic [ROWS-1:0]   bitcolumn_d;
    logic [COLS-1:0]   bitrowtop_d;
    logic [COLS-1:0]   bitrowbot_d;
    logic              colrdy_d;
    logic              rowrdy_d;
    logic              busy_d;
    logic              feed_done_d;

    logic              serve_col;
    logic              serve_row;
    logic              tmo_hit;

    logic [COLS-1:0]   rd_top;
    logic [COLS-1:0]   rd_bot;
    logic [ROWS-1:0]   rd_col;

    cmp_bitbuf u_buf (
        .clk       (clk),
        .we        (wr_en_q),
        .waddr     (wr_idx_q),
        .wdata     (mem_rdata),
        .raddr_top (top_q),
        .rdata_top (rd_top),
        .raddr_bot (bot_q),
        .rdata_bot (rd_bot),
        .cidx      (col_q),
        .cdata     (rd_col)
    );

    // Both sides drained and the ALU never said done
    assign tmo_hit = col_exh_q && row_exh_q && (tmo_q == '1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FEED_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FEED_IDLE, FEED_DONE: if (start) state_d = FEED_LOAD;
            FEED_LOAD:            if (lcnt_q == LCNT_W'(ROWS)) state_d = FEED_STREAM;
            FEED_STREAM:          if (cmp_done || tmo_hit) state_d = FEED_DONE;
            default:              state_d = FEED_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        lcnt_d      = lcnt_q;
        col_d       = col_q;
        top_d       = top_q;
        bot_d       = bot_q;
        col_exh_d   = col_exh_q;
        row_exh_d   = row_exh_q;
        primed_d    = primed_q;
        tmo_d       = tmo_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr;
        bitcolumn_d = bitcolumn;
        bitrowtop_d = bitrowtop;
        bitrowbot_d = bitrowbot;
        colrdy_d    = 1'b0;
        rowrdy_d    = 1'b0;
        serve_col   = 1'b0;
        serve_row   = 1'b0;
        alustart_d  = (state_q == FEED_LOAD) && (state_d == FEED_STREAM);
        busy_d      = (state_d == FEED_LOAD) || (state_d == FEED_STREAM);
        feed_done_d = (state_d == FEED_DONE);

        case (state_q)
            FEED_IDLE, FEED_DONE: begin
                if (start) begin
                    lcnt_d     = '0;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = base_addr;
                    col_d      = '0;
                    top_d      = '0;
                    bot_d      = ROW_W'(ROWS - 1);
                    col_exh_d  = 1'b0;
                    row_exh_d  = 1'b0;
                    primed_d   = 1'b0;
                    tmo_d      = '0;
                end
            end
            FEED_LOAD: begin
                lcnt_d = lcnt_q + LCNT_W'(1);
                if (lcnt_q < LCNT_W'(ROWS - 1)) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = mem_addr + ADDR_W'(1);
                end
            end
            FEED_STREAM: begin
                if (!cmp_done) begin
                    // The unprimed first cycle behaves like a request on both sides
                    serve_col = !primed_q ||
                                (nextcolumn && !nextcolumnready && !col_exh_q);
                    serve_row = !primed_q ||
                                (nextrow && !nextrowtopready && !row_exh_q);
                    primed_d  = 1'b1;

                    if (serve_col) begin
                        bitcolumn_d = rd_col;
                        colrdy_d    = 1'b1;
                        if (col_q == COL_W'(COLS - 1)) begin
                            col_exh_d = 1'b1;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end

                    if (serve_row) begin
                        bitrowtop_d = rd_top;
                        bitrowbot_d = rd_bot;
                        rowrdy_d    = 1'b1;
                        if (top_q == ROW_W'(ROWS - 1)) begin
                            row_exh_d = 1'b1;
                        end else begin
                            top_d = top_q + ROW_W'(1);
                            bot_d = bot_q - ROW_W'(1);
                        end
                    end

                    if (col_exh_q && row_exh_q) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt_q          <= '0;
            wr_en_q         <= 1'b0;
            wr_idx_q        <= '0;
            col_q           <= '0;
            top_q           <= '0;
            bot_q           <= ROW_W'(ROWS - 1);
            col_exh_q       <= 1'b0;
            row_exh_q       <= 1'b0;
            primed_q        <= 1'b0;
            tmo_q           <= '0;
            mem_rd          <= 1'b0;
            mem_addr        <= '0;
            alustart        <= 1'b0;
            bitcolumn       <= '0;
            nextcolumnready <= 1'b0;
            bitrowtop       <= '0;
            nextrowtopready <= 1'b0;
            bitrowbot       <= '0;
            nextrowbotready <= 1'b0;
            busy            <= 1'b0;
            feed_done       <= 1'b0;
        end else begin
            lcnt_q          <= lcnt_d;
            // Read data returns one cycle after the strobe; lcnt still names its row
            wr_en_q         <= mem_rd;
            wr_idx_q        <= ROW_W'(lcnt_q);
            col_q           <= col_d;
            top_q           <= top_d;
            bot_q           <= bot_d;
            col_exh_q       <= col_exh_d;
            row_exh_q       <= row_exh_d;
            primed_q        <= primed_d;
            tmo_q           <= tmo_d;
            mem_rd          <= mem_rd_d;
            mem_addr        <= mem_addr_d;
            alustart        <= alustart_d;
            bitcolumn       <= bitcolumn_d;
            nextcolumnready <= colrdy_d;
            bitrowtop       <= bitrowtop_d;
            nextrowtopready <= rowrdy_d;
            bitrowbot       <= bitrowbot_d;
            nextrowbotready <= rowrdy_d;
            busy            <= busy_d;
            feed_done       <= feed_done_d;
        end
    end

endmodule

// File: tb/tb_cmp_bitfeed.sv
// Scoreboard bench for cmp_bitfeed: the driver pushes expected words as it
// issues requests; independent negedge monitors pop and compare on each strobe.
module tb_cmp_bitfeed;
    import cmp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [23:0] mem_rdata = '0;
    logic        alustart;
    logic        nextcolumn = 1'b0;
    logic        nextrow = 1'b0;
    logic        cmp_done = 1'b0;
    logic [63:0] bitcolumn;
    logic        nextcolumnready;
    logic [23:0] bitrowtop;
    logic        nextrowtopready;
    logic [23:0] bitrowbot;
    logic        nextrowbotready;
    logic        busy;
    logic        feed_done;

    always #5 clk = ~clk;

    cmp_bitfeed dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .base_addr       (base_addr),
        .mem_rd          (mem_rd),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .alustart        (alustart),
        .nextcolumn      (nextcolumn),
        .nextrow         (nextrow),
        .cmp_done        (cmp_done),
        .bitcolumn       (bitcolumn),
        .nextcolumnready (nextcolumnready),
        .bitrowtop       (bitrowtop),
        .nextrowtopready (nextrowtopready),
        .bitrowbot       (bitrowbot),
        .nextrowbotready (nextrowbotready),
        .busy            (busy),
        .feed_done       (feed_done)
    );

    int checks = 0;
    int failures = 0;

    logic [23:0] tb_mem [65536];
    logic [23:0] img [64];

    logic [63:0] exp_col[$];
    logic [23:0] exp_top[$];
    logic [23:0] exp_bot[$];
    logic [15:0] exp_addr[$];
    int          n_colpulse = 0;

    // Reference model state (requests served so far, pulse pending, streaming)
    int ncol = 0;
    int nrow = 0;
    bit pend_c = 1'b0;
    bit pend_r = 1'b0;
    bit active = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] col_word(input int c);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < 64; j++) begin
            logic [23:0] w;
            w = img[j] >> c;
            v = v | (64'(w[0]) << j);
        end
        return v;
    endfunction

    // Image memory: data driven during the cycle after the strobe
    logic        rd_pend = 1'b0;
    logic [15:0] addr_pend = '0;
    always @(negedge clk) begin
        mem_rdata = rd_pend ? tb_mem[addr_pend] : 24'($urandom);
        rd_pend   = mem_rd;
        addr_pend = mem_addr;
    end

    // Monitor: pop and compare on every strobe
    always @(negedge clk) begin
        if (mem_rd) begin
            check("mem_rd_expected", 64'(exp_addr.size() != 0), 64'd1);
            if (exp_addr.size() != 0) check("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
        end
        if (nextcolumnready) begin
            n_colpulse++;
            check("col_pulse_expected", 64'(exp_col.size() != 0), 64'd1);
            if (exp_col.size() != 0) check("bitcolumn", bitcolumn, exp_col.pop_front());
        end
        if (nextrowtopready) begin
            check("top_pulse_expected", 64'(exp_top.size() != 0), 64'd1);
            if (exp_top.size() != 0) check("bitrowtop", 64'(bitrowtop), 64'(exp_top.pop_front()));
        end
        if (nextrowbotready) begin
            check("bot_pulse_expected", 64'(exp_bot.size() != 0), 64'd1);
            if (exp_bot.size() != 0) check("bitrowbot", 64'(bitrowbot), 64'(exp_bot.pop_front()));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One cycle of ALU-side stimulus; the model decides what the feeder owes
    task automatic step(input bit c, input bit r, input bit d, input bit s);
        bit acc_c, acc_r;
        nextcolumn = c;
        nextrow    = r;
        cmp_done   = d;
        start      = s;
        acc_c = active && c && !d && !pend_c && (ncol < 24);
        acc_r = active && r && !d && !pend_r && (nrow < 64);
        if (acc_c) begin
            exp_col.push_back(col_word(ncol));
            ncol++;
        end
        if (acc_r) begin
            exp_top.push_back(img[nrow]);
            exp_bot.push_back(img[63 - nrow]);
            nrow++;
        end
        if (d) active = 1'b0;
        pend_c = acc_c;
        pend_r = acc_r;
        tick();
        nextcolumn = 1'b0;
        nextrow    = 1'b0;
        cmp_done   = 1'b0;
        start      = 1'b0;
    endtask

    task automatic fill(input bit rnd, input logic [15:0] b);
        for (int r = 0; r < 64; r++) begin
            img[r] = rnd ? 24'($urandom) : (24'h000001 << (r % 24));
            tb_mem[16'(b + 16'(r))] = img[r];
        end
    endtask

    task automatic launch(input logic [15:0] b);
        for (int r = 0; r < 64; r++) exp_addr.push_back(16'(b + 16'(r)));
        base_addr = b;
        active = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait for alustart (launch tick counts as 1), queue the prime, step into the prime cycle
    task automatic wait_stream();
        int lat;
        lat = 1;
        while (!alustart && lat < 200) begin
            tick();
            lat++;
        end
        check("alustart_latency", 64'(lat - 1), 64'd65);
        check("addr_queue_drained", 64'(exp_addr.size()), 64'd0);
        check("busy_stream", 64'(busy), 64'd1);
        exp_col.push_back(col_word(0));
        exp_top.push_back(img[0]);
        exp_bot.push_back(img[63]);
        ncol = 1;
        nrow = 1;
        tick();
        active = 1'b1;
        pend_c = 1'b1;
        pend_r = 1'b1;
        check("alustart_single", 64'(alustart), 64'd0);
    endtask

    initial begin
        logic [15:0] b2;
        logic [15:0] b3;
        int          lat;
        bit          found;

        // Reset
        rst = 1'b1;
        tick(); tick(); tick();
        check("rst_ctrl", 64'({mem_rd, alustart, nextcolumnready, nextrowtopready,
                               nextrowbotready, busy, feed_done}), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_col", bitcolumn, 64'd0);
        check("rst_rows", 64'({bitrowtop, bitrowbot}), 64'd0);
        rst = 1'b0;
        tick();

        // Spec pattern, base near top of address space to exercise wrap
        fill(1'b0, 16'hFFF0);
        launch(16'hFFF0);
        wait_stream();
        check("prime_pulses", 64'({nextcolumnready, nextrowtopready, nextrowbotready}), 64'd7);
        check("prime_col", bitcolumn, 64'h0001_0000_0100_0001);
        check("prime_top", 64'(bitrowtop), 64'h000001);
        check("prime_bot", 64'(bitrowbot), 64'h008000);

        // Requests in a ready-pulse cycle are dropped; then both at once
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("dual_pulses", 64'({nextcolumnready, nextrowtopready, nextrowbotready}), 64'd7);
        check("dual_top_row1", 64'(bitrowtop), 64'(img[1]));
        check("dual_bot_row62", 64'(bitrowbot), 64'(img[62]));

        // Remaining columns every other cycle, then one past the end
        step(0, 0, 0, 0);
        for (int i = 0; i < 22; i++) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
        step(1, 0, 0, 0);
        check("col_exhaust_nopulse", 64'(nextcolumnready), 64'd0);
        check("col_exhaust_hold", bitcolumn, col_word(23));
        check("col_pulse_count", 64'(n_colpulse), 64'd24);
        check("col_queue_empty", 64'(exp_col.size()), 64'd0);

        // Three more rows (five per side), then cmp_done with requests
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            step(0, 0, 0, 0);
        end
        step(1, 1, 1, 0);
        check("done_flag", 64'(feed_done), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_nopulse", 64'({nextcolumnready, nextrowtopready, nextrowbotready}), 64'd0);
        step(1, 1, 0, 0);
        check("done_hold_top", 64'(bitrowtop), 64'(img[4]));
        check("done_hold_bot", 64'(bitrowbot), 64'(img[59]));
        check("done_hold_col", bitcolumn, col_word(23));
        check("row_queue_empty", 64'(exp_top.size() + exp_bot.size()), 64'd0);

        // Reset mid-LOAD at row 30
        b2 = 16'($urandom);
        fill(1'b1, b2);
        launch(b2);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mem_rd && mem_addr == 16'(b2 + 16'd30)) found = 1'b1;
            else tick();
        end
        check("abort_point_found", 64'(found), 64'd1);
        exp_addr.delete();
        rst = 1'b1;
        tick();
        check("abort_ctrl", 64'({mem_rd, alustart, nextcolumnready, nextrowtopready,
                                 nextrowbotready, busy, feed_done}), 64'd0);
        check("abort_data", 64'(bitcolumn | 64'({bitrowtop, bitrowbot})), 64'd0);
        rst = 1'b0;
        tick();

        // Fresh random image reloads everything
        b3 = 16'($urandom);
        fill(1'b1, b3);
        launch(b3);
        wait_stream();

        // start during STREAM is ignored; pointers continue from col 1 / row 1
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        check("start_ignored_busy", 64'(busy), 64'd1);
        check("start_ignored_col1", bitcolumn, col_word(1));

        // Random request mix until both sides are exhausted (top/bot cross)
        for (int i = 0; i < 3000 && (ncol < 24 || nrow < 64); i++) begin
            step(1'($urandom), 1'($urandom), 0, 0);
        end
        check("exhausted", 64'({ncol == 24, nrow == 64}), 64'd3);

        // Timeout guard: DONE 256 cycles after the last pulse
        lat = 0;
        while (!feed_done && lat < 400) begin
            step(1'($urandom), 1'($urandom), 0, 0);
            lat++;
        end
        check("timeout_cycles", 64'(lat), 64'd256);
        check("timeout_busy", 64'(busy), 64'd0);
        check("final_queues", 64'(exp_col.size() + exp_top.size() + exp_bot.size()), 64'd0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
